fetch_stage: RTL

- Instruction-fetch stage of the pipelined core: holds the PC, drives the instruction-memory address and registers the fetched word into the IF/ID pipeline register.
- Sits directly upstream of decode; its IF/ID outputs feed the control unit and the register file.
- Handles sequential fetch, branch/jump redirects from execute, and hazard-unit stalls and flushes.

---
 rtl/fetch_stage.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// Instruction-fetch stage: PC register, instruction-memory address and IF/ID pipeline register.
// Defining FETCH_PERF_CNT_EN adds the FetchCount/FlushCount performance counters.
module fetch_stage #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     StallF,
    input  logic                     StallD,
    input  logic                     FlushD,
    input  logic                     PCSrcE,
    input  logic [ADDRESS_WIDTH-1:0] PCTargetE,
    output logic [ADDRESS_WIDTH-1:0] PCF,
    input  logic [DATA_WIDTH-1:0]    RD,
    output logic [DATA_WIDTH-1:0]    InstrD,
    output logic [ADDRESS_WIDTH-1:0] PCD,
    output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
    output logic                     ValidD,
    output logic [6:0]               OpD,
    output logic [2:0]               Funct3D,
    output logic                     Funct7D,
    output logic [4:0]               Rs1D,
    output logic [4:0]               Rs2D,
    output logic [4:0]               RdD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              FetchCount,
    output logic [31:0]              FlushCount
`endif
);

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

    logic [ADDRESS_WIDTH-1:0] r_pcf_p0;
    logic [ADDRESS_WIDTH-1:0] w_pcplus4_p0;
    logic [ADDRESS_WIDTH-1:0] w_pcnext_p0;
    logic                     w_kill_p0;
    logic                     w_unused_tgt_lsb;

    logic [DATA_WIDTH-1:0]    r_instr_p1;
    logic [ADDRESS_WIDTH-1:0] r_pc_p1;
    logic [ADDRESS_WIDTH-1:0] r_pcplus4_p1;
    logic                     r_vld_p1;

    // Stage p0: PC selection; redirect targets are forced word-aligned
    assign w_pcplus4_p0     = r_pcf_p0 + ADDRESS_WIDTH'(4);
    assign w_pcnext_p0      = PCSrcE ? {PCTargetE[ADDRESS_WIDTH-1:2], 2'b00} : w_pcplus4_p0;
    assign w_kill_p0        = FlushD | PCSrcE;
    assign w_unused_tgt_lsb = ^PCTargetE[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcf_p0 <= RESET_PC;
        end else if (PCSrcE || !StallF) begin
            r_pcf_p0 <= w_pcnext_p0;
        end
    end

    // Stage p1: IF/ID register; a kill beats a decode stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_p1   <= NOP_INSTR;
            r_pc_p1      <= '0;
            r_pcplus4_p1 <= '0;
            r_vld_p1     <= 1'b0;
        end else if (w_kill_p0) begin
            r_instr_p1   <= NOP_INSTR;
            r_pc_p1      <= '0;
            r_pcplus4_p1 <= '0;
            r_vld_p1     <= 1'b0;
        end else if (!StallD) begin
            r_instr_p1   <= RD;
            r_pc_p1      <= r_pcf_p0;
            r_pcplus4_p1 <= w_pcplus4_p0;
            r_vld_p1     <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_kill_p0) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end else if (!StallD) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign FetchCount = r_fetch_cnt;
    assign FlushCount = r_flush_cnt;
`endif

    assign PCF      = r_pcf_p0;
    assign InstrD   = r_instr_p1;
    assign PCD      = r_pc_p1;
    assign PCPlus4D = r_pcplus4_p1;
    assign ValidD   = r_vld_p1;
    assign OpD      = r_instr_p1[6:0];
    assign Funct3D  = r_instr_p1[14:12];
    assign Funct7D  = r_instr_p1[30];
    assign Rs1D     = r_instr_p1[19:15];
    assign Rs2D     = r_instr_p1[24:20];
    assign RdD      = r_instr_p1[11:7];

endmodule
